pipe_stage_reg: RTL

Parametrised valid/ready pipeline stage register for the LC-3b pipeline, replacing the fixed-field, advance-strobed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Carries a packed payload of configurable width, adds a valid/ready handshake with back-pressure, synchronous flush with bubble insertion, an optional two-entry skid buffer, and a saturating stall counter for performance analysis. One instance sits between each pair of adjacent pipeline stages.

---
 rtl/lc3b_types.sv | 59 +++++
 rtl/pipe_stage_reg_skid_entry.sv | 23 ++
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: pipeline payload structs, stage-register state encoding
// and the NOP control word loaded into bubbles.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] aluop;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
    logic       br_en;
    logic [4:0] mux_sel;
  } lc3b_control_word;

  localparam lc3b_control_word PIPE_BUBBLE_CW = '0;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word ir;
  } lc3b_pipe_ifid_t;

  typedef struct packed {
    lc3b_word         pc;
    lc3b_control_word cw;
    lc3b_word         sr1_data;
    lc3b_word         sr2_data;
    lc3b_word         offset;
    lc3b_reg          dest;
  } lc3b_pipe_idex_t;

  typedef struct packed {
    lc3b_word         pc;
    lc3b_control_word cw;
    lc3b_word         alu_out;
    lc3b_word         store_data;
    lc3b_reg          dest;
  } lc3b_pipe_exmem_t;

  typedef struct packed {
    lc3b_control_word cw;
    lc3b_word         result;
    lc3b_reg          dest;
  } lc3b_pipe_memwb_t;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  // Stage-register FSM encoding, kept numerically identical to pipe_state_t.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_stage_reg_skid_entry.sv
// Single holding register with synchronous load and clear; used as the skid
// entry of pipe_stage_reg when PIPE_SKID_EN is defined.
module pipe_skid_entry #(
  parameter int unsigned       WIDTH  = 64,
  parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush and stall counter.
// Define PIPE_SKID_EN for the two-entry skid build with a registered in_ready.
//
// Handshake: a beat moves on a rising edge when valid && ready on that
// interface; out_data holds steady while out_valid=1 and out_ready=0.
module pipe_stage_reg
  import lc3b_types::*;
#(
  parameter int unsigned      WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_count
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       accept;
  logic       pop;
  logic       load_out_in;

`ifdef PIPE_SKID_EN
  logic             load_out_skid;
  logic             load_skid;
  logic             ready_q;
  logic [WIDTH-1:0] skid_data;
`endif

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_next  = state;
    load_out_in = 1'b0;
`ifdef PIPE_SKID_EN
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
`endif
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_next  = ST_ONE;
          load_out_in = 1'b1;
        end
      end
      ST_ONE: begin
`ifdef PIPE_SKID_EN
        if (accept && pop) begin
          load_out_in = 1'b1;
        end else if (accept) begin
          state_next = ST_TWO;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = ST_EMPTY;
        end
`else
        // in_ready tracks out_ready while full, so accept implies pop here.
        if (accept) begin
          load_out_in = 1'b1;
        end else if (pop) begin
          state_next = ST_EMPTY;
        end
`endif
      end
`ifdef PIPE_SKID_EN
      ST_TWO: begin
        if (pop) begin
          state_next    = ST_ONE;
          load_out_skid = 1'b1;
        end
      end
`endif
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= BUBBLE;
    end else begin
      state     <= state_next;
      out_valid <= (state_next != ST_EMPTY);
      if (load_out_in) begin
        out_data <= in_data;
`ifdef PIPE_SKID_EN
      end else if (load_out_skid) begin
        out_data <= skid_data;
`endif
      end
    end
  end

  // Performance counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

`ifdef PIPE_SKID_EN
  // Ready comes from a flop so the downstream ready chain is cut here.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_next != ST_TWO);
    end
  end

  assign in_ready = ready_q && !reset;

  pipe_skid_entry #(
    .WIDTH  (WIDTH),
    .BUBBLE (BUBBLE)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (load_skid),
    .d     (in_data),
    .q     (skid_data)
  );
`else
  assign in_ready = !reset && (!out_valid || out_ready);
`endif

endmodule
